// File: rtl/mem_bus_unit.sv
// mem_bus_unit
//   Memory bus interface between a CPU control unit and a single-cycle-ack
//   memory bus. It holds the memory address register (MAR) and the memory
//   buffer register (MBR), and runs one word or byte access per MFA request.
//
//   Optional feature: define MEM_TIMEOUT_EN to enable the bus-wait timeout.
//   If an access sees no mem_ack within TIMEOUT_CYCLES request cycles, it ends
//   with BUS_ERR = 1. Without the macro, BUS_ERR is tied low and a request
//   waits for mem_ack indefinitely.
//
// Ports
//   Clk, Reset          clock and synchronous active-high reset
//   MFA                 memory-function-activate (starts an access in IDLE,
//                       holds DONE while high)
//   READ_WRITE          1 = read, 0 = write (sampled with MFA)
//   WORD_BYTE           1 = 32-bit word, 0 = byte (sampled with MFA)
//   MARLOAD, MBRLOAD    load MAR / MBR from Din (only honoured in IDLE)
//   MBRSTORE            drive MBR onto MBR_OUT
//   Din [31:0]          internal result bus
//   MFC                 memory-function-complete
//   BUS_ERR             last access ended by timeout
//   MBR_OUT [31:0]      MBR when MBRSTORE = 1, else 0
//   mem_addr [31:0]     word-aligned address {MAR[31:2], 2'b00}
//   mem_req, mem_we     bus request and write enable
//   mem_be [3:0]        byte-lane enables
//   mem_wdata [31:0]    write data
//   mem_rdata [31:0]    read data, valid with mem_ack
//   mem_ack             single-cycle completion strobe
module mem_bus_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MFA,
  input  logic        READ_WRITE,
  input  logic        WORD_BYTE,
  input  logic        MARLOAD,
  input  logic        MBRLOAD,
  input  logic        MBRSTORE,
  input  logic [31:0] Din,
  output logic        MFC,
  output logic        BUS_ERR,
  output logic [31:0] MBR_OUT,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mar_q, mar_d;
  logic [31:0] mbr_q, mbr_d;
  logic        rw_q, rw_d;   // latched READ_WRITE
  logic        wb_q, wb_d;   // latched WORD_BYTE
  logic [7:0]  rd_lane;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          berr_q, berr_d;
`endif

  // Byte lane of the read data addressed by MAR[1:0].
  assign rd_lane = mem_rdata[8*mar_q[1:0] +: 8];

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mbr_d   = mbr_q;
    rw_d    = rw_q;
    wb_d    = wb_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    berr_d  = berr_q;
`endif
    case (state_q)
      IDLE: begin
        // Loads and MFA may coincide; the access then uses the new values
        // because the bus outputs are driven from the registers in REQ.
        if (MARLOAD) mar_d = Din;
        if (MBRLOAD) mbr_d = Din;
        if (MFA) begin
          rw_d    = READ_WRITE;
          wb_d    = WORD_BYTE;
          state_d = REQ;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
          berr_d  = 1'b0;
`endif
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = DONE;
          if (rw_q) mbr_d = wb_q ? mem_rdata : {24'h0, rd_lane};
        end
`ifdef MEM_TIMEOUT_EN
        // An ack arriving in the limit cycle wins over the timeout.
        else if (cnt_q == LIMIT) begin
          state_d = DONE;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      DONE: begin
        if (!MFA) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mbr_q   <= '0;
      rw_q    <= 1'b0;
      wb_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
      berr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mbr_q   <= mbr_d;
      rw_q    <= rw_d;
      wb_q    <= wb_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      berr_q  <= berr_d;
`endif
    end
  end

  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_req & ~rw_q;
  assign mem_be    = mem_req ? (wb_q ? 4'hF : (4'b0001 << mar_q[1:0])) : 4'h0;
  assign mem_wdata = wb_q ? mbr_q : {4{mbr_q[7:0]}};
  assign mem_addr  = {mar_q[31:2], 2'b00};
  assign MFC       = (state_q == DONE);
  assign MBR_OUT   = MBRSTORE ? mbr_q : 32'h0;
`ifdef MEM_TIMEOUT_EN
  assign BUS_ERR   = berr_q;
`else
  assign BUS_ERR   = 1'b0;
`endif

endmodule
